io_event_arbiter: RTL and testbench
===================================

Name: io_event_arbiter

Overview:
- Shares the register file's single hardware-event write path among four game I/O sources: button, screen, collision and pause.
- Each source delivers a 32-bit value over a valid/ready handshake. The block buffers one value per source and grants sources round-robin.
- It issues one registered write per cycle: io_we / io_waddr / io_wdata, targeting that source's fixed register.
- It defers a source whenever the CPU writes the same register in the selection cycle, so hardware data always lands after the CPU write.

Parameters:
DATA_W, 32, width of event data and register write data
ADDR_W, 5, register index width
CNT_W, 8, width of the saturating conflict counter

Ports:
clock  in  1  system clock, rising edge
ctrl_reset_n  in  1  asynchronous active-low reset
src_valid  in  4  per-source valid; bit0 button, bit1 screen, bit2 collision, bit3 pause
src_data  in  4*DATA_W  per-source data; source i occupies bits [i*DATA_W +: DATA_W]
src_ready  out  4  per-source ready
cpu_we  in  1  CPU write enable into the register file
cpu_waddr  in  ADDR_W  CPU write register index
io_we  out  1  registered hardware-write enable to the register file
io_waddr  out  ADDR_W  registered target register index
io_wdata  out  DATA_W  registered write data
io_grant_id  out  2  source that owns the current io_we pulse
io_busy  out  1  high when any pending bit is set
conflict_count  out  CNT_W  saturating count of CPU-collision deferrals

Behaviour:
- Fixed target map: src0 -> 20, src1 -> 22, src2 -> 24, src3 -> 26.
- State:
  - pend[3:0]: one pending bit per source.
  - buf[i]: DATA_W-bit buffer per source.
  - rr_ptr: 2 bits.
  - Output registers and conflict_count.
- Reset (ctrl_reset_n low, asynchronous), all of the following cleared:
  - pend = 0, rr_ptr = 0, io_we = 0, io_waddr = 0, io_wdata = 0, io_grant_id = 0, conflict_count = 0.
  - src_ready is forced to 0 while reset is asserted.
  - Reset mid-operation discards all buffered events. No write is issued after reset release until a new acceptance.
- Eligibility, per cycle: source i is eligible when pend[i]=1 AND NOT (cpu_we=1 AND cpu_waddr = target(i)).
- Selection:
  - Combinational scan of eligible sources, starting at rr_ptr and proceeding rr_ptr+1, +2, +3 (mod 4).
  - The first eligible source is sel; sel_vld means one was found.
- Clock edge, when sel_vld=1:
  - io_we <= 1, io_waddr <= target(sel), io_wdata <= buf[sel], io_grant_id <= sel.
  - pend[sel] <= 0.
  - rr_ptr <= sel + 1 (mod 4).
- Clock edge, when sel_vld=0: io_we <= 0; the other output registers hold their values.
- Handshake:
  - src_ready[i] = ~pend[i] | (sel_vld & sel == i).
  - Accept on src_valid[i] & src_ready[i]: buf[i] <= data, pend[i] <= 1.
  - When a grant and an accept for the same source occur in the same cycle, the accept wins: pend[i] stays 1 and buf[i] takes the new data.
  - A source presenting valid while not ready must hold its data stable. Nothing is dropped.
- Latency:
  - Value accepted at edge t with no contention -> io_we high during the cycle following edge t+1.
  - Throughput is one write per cycle, shared across sources.
- Fairness: a continuously pending, non-blocked source is granted within 4 cycles.
- CPU conflict:
  - conflict_count increments by 1 (saturating at 2^CNT_W - 1) on each edge where at least one pending source is ineligible solely because of a cpu_waddr match.
  - When every pending source is blocked, io_we=0 for that cycle.
- io_busy = |pend (combinational from state).
- Outputs io_* come directly from flops. src_ready is combinational from state plus cpu_we/cpu_waddr.

Decomposition:
- Shared package io_map_pkg holds:
  - source index constants SRC_BUTTON=0, SRC_SCREEN=1, SRC_COLLISION=2, SRC_PAUSE=3;
  - register index constants REG_BUTTON=20, REG_SCREEN=22, REG_COLLISION=24, REG_PAUSE=26;
  - NUM_SRC=4.
- One natural sub-module: rr_pick4 (combinational rotate-priority selector: eligible[3:0] + rr_ptr -> sel, sel_vld).
- The pending/buffer slots and the output registers stay in the top module.

Test Plan:
- Single event: after reset, src0 valid with 0x0000_0001 for one cycle -> one cycle later io_we=1, io_waddr=20, io_wdata=0x1, io_grant_id=0; io_busy is 1 in the intervening cycle and then returns to 0.
- Round-robin: all four sources valid in the same cycle with data 0xA0..0xA3 -> io_we high 4 consecutive cycles with io_waddr 20, 22, 24, 26 in that order; then rr_ptr=0; src3 re-posts -> granted next.
- CPU conflict: src2 pending while cpu_we=1, cpu_waddr=24 for 3 cycles -> no write to 24 during those 3 cycles; conflict_count=3; the write to 24 is issued on the first cycle after cpu_we drops.
- Back-to-back same source: src1 valid continuously with 0x10, 0x11, 0x12 -> src_ready stays 1 after the first accept; writes to 22 carry 0x10, 0x11, 0x12 in order, one per cycle, with no loss.
- Backpressure: src0 pending and blocked by CPU; src0 asserts valid with 0x55 -> src_ready[0]=0 and buf[0] is unchanged; after unblocking, 0x55 is written on the cycle after the first value.
- Reset mid-operation: three sources pending; ctrl_reset_n pulsed low between edges -> io_we=0 and io_busy=0 immediately, conflict_count=0; no writes after release.

Source files
------------

// File: rtl/io_map_pkg.sv
// Shared map of game I/O event sources and the register-file slots they
// update. Imported by the arbiter and by anything that needs to know which
// register a given hardware event lands in.
package io_map_pkg;

  localparam int NUM_SRC = 4;

  // Source indices, matching the bit positions of src_valid / src_ready.
  localparam int SRC_BUTTON    = 0;
  localparam int SRC_SCREEN    = 1;
  localparam int SRC_COLLISION = 2;
  localparam int SRC_PAUSE     = 3;

  // Register-file slots owned by each hardware event source.
  localparam int unsigned REG_BUTTON    = 20;
  localparam int unsigned REG_SCREEN    = 22;
  localparam int unsigned REG_COLLISION = 24;
  localparam int unsigned REG_PAUSE     = 26;

  // Fixed source -> register index mapping.
  function automatic int unsigned target_reg(input int unsigned src);
    case (src)
      SRC_BUTTON:    return REG_BUTTON;
      SRC_SCREEN:    return REG_SCREEN;
      SRC_COLLISION: return REG_COLLISION;
      default:       return REG_PAUSE;
    endcase
  endfunction

endpackage

// File: rtl/io_event_arbiter_rr_pick4.sv
// Four-way rotating-priority picker: the scan starts at rr_ptr and wraps,
// and the first eligible source wins.
module rr_pick4 (
  input  logic [3:0] eligible,
  input  logic [1:0] rr_ptr,
  output logic [1:0] sel,
  output logic       sel_vld
);

  logic [7:0] doubled;
  logic [3:0] rotated;
  logic [1:0] offset;

  // Rotate so that bit 0 of 'rotated' is the source at rr_ptr.
  assign doubled = {eligible, eligible};
  assign rotated = doubled[rr_ptr +: 4];

  // Priority-encode the rotated vector, then map back to a source index.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned and infers a latch.
    offset  = 2'd0;
    sel_vld = |rotated;
    if (rotated[0])      offset = 2'd0;
    else if (rotated[1]) offset = 2'd1;
    else if (rotated[2]) offset = 2'd2;
    else if (rotated[3]) offset = 2'd3;
    sel = rr_ptr + offset;
  end

endmodule

// File: rtl/io_event_arbiter.sv
// Funnels button / screen / collision / pause events into the register
// file's single hardware write port. One value is buffered per source,
// sources are served round-robin, and a source is held back in any cycle
// where the CPU is writing the same register so the hardware value always
// lands after the CPU's.
module io_event_arbiter
  import io_map_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic                      clock,
  input  logic                      ctrl_reset_n,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_waddr,
  output logic                      io_we,
  output logic [ADDR_W-1:0]         io_waddr,
  output logic [DATA_W-1:0]         io_wdata,
  output logic [1:0]                io_grant_id,
  output logic                      io_busy,
  output logic [CNT_W-1:0]          conflict_count
);

  logic [NUM_SRC-1:0] pend;
  logic [DATA_W-1:0]  slot_data [NUM_SRC];
  logic [1:0]         rr_ptr;

  logic [ADDR_W-1:0]  tgt       [NUM_SRC];
  logic [NUM_SRC-1:0] cpu_hit;
  logic [NUM_SRC-1:0] blocked;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] grant_vec;
  logic [NUM_SRC-1:0] accept;
  logic [NUM_SRC-1:0] pend_next;
  logic [1:0]         sel;
  logic               sel_vld;

  // Per-source target register and CPU same-register collision detect.
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign tgt[i]     = ADDR_W'(target_reg(i));
    assign cpu_hit[i] = cpu_we & (cpu_waddr == tgt[i]);
  end

  assign blocked  = pend & cpu_hit;
  assign eligible = pend & ~cpu_hit;

  rr_pick4 u_pick (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .sel      (sel),
    .sel_vld  (sel_vld)
  );

  // A slot can take a new value when empty or when it is being drained this
  // cycle; ready is held low while reset is asserted.
  assign grant_vec = sel_vld ? (NUM_SRC'(1) << sel) : '0;
  assign src_ready = (~pend | grant_vec) & {NUM_SRC{ctrl_reset_n}};
  assign accept    = src_valid & src_ready;
  // A same-cycle accept on the granted slot re-arms it with the new value.
  assign pend_next = (pend & ~grant_vec) | accept;
  assign io_busy   = |pend;

  // Pending flags, rotation pointer, write-port registers and conflict count.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      pend           <= '0;
      rr_ptr         <= 2'd0;
      io_we          <= 1'b0;
      io_waddr       <= '0;
      io_wdata       <= '0;
      io_grant_id    <= 2'd0;
      conflict_count <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      pend <= pend_next;
      if (sel_vld) begin
        io_we       <= 1'b1;
        io_waddr    <= tgt[sel];
        io_wdata    <= slot_data[sel];
        io_grant_id <= sel;
        rr_ptr      <= sel + 2'd1;
      end else begin
        io_we <= 1'b0;
      end
      if ((|blocked) && (conflict_count != {CNT_W{1'b1}})) begin
        conflict_count <= conflict_count + CNT_W'(1);
      end
    end
  end

  // Event data slots, loaded on acceptance.
  // NOTE: the data slots are deliberately left out of reset; a slot is only
  // read while its pend bit is set, and pend is reset.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accept[i]) begin
        slot_data[i] <= src_data[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_io_event_arbiter.sv
// Self-checking bench for io_event_arbiter: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural model of
// the event slots, rotation order and conflict counting.
module tb_io_event_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic [3:0]  v;
  logic [31:0] d [4];
  logic [127:0] src_data;
  logic [3:0]  src_ready;
  logic        cwe;
  logic [4:0]  cwa;
  logic        io_we;
  logic [4:0]  io_waddr;
  logic [31:0] io_wdata;
  logic [1:0]  io_grant_id;
  logic        io_busy;
  logic [7:0]  conflict_count;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  bit          m_pend [4];
  logic [31:0] m_buf  [4];
  int          m_ptr;
  logic        m_we;
  int          m_waddr;
  logic [31:0] m_wdata;
  int          m_gid;
  int          m_cnt;
  // Per-cycle model decisions.
  int          m_sel;
  bit          m_any_blk;
  logic [3:0]  m_ready;
  logic [3:0]  m_acc;

  assign src_data = {d[3], d[2], d[1], d[0]};

  always #5 clock = ~clock;

  io_event_arbiter dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .src_valid      (v),
    .src_data       (src_data),
    .src_ready      (src_ready),
    .cpu_we         (cwe),
    .cpu_waddr      (cwa),
    .io_we          (io_we),
    .io_waddr       (io_waddr),
    .io_wdata       (io_wdata),
    .io_grant_id    (io_grant_id),
    .io_busy        (io_busy),
    .conflict_count (conflict_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int reg_of(input int src);
    return 20 + 2 * src;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_pend[i] = 0;
    m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_gid = 0; m_cnt = 0;
  endfunction

  // What the arbiter should decide this cycle, from the current inputs.
  function automatic void m_comb();
    m_sel = -1;
    m_any_blk = 0;
    for (int k = 0; k < 4; k++) begin
      int idx;
      bit hit;
      idx = (m_ptr + k) % 4;
      hit = cwe && (int'(cwa) == reg_of(idx));
      if (m_pend[idx] && hit) m_any_blk = 1;
      if (m_sel < 0 && m_pend[idx] && !hit) m_sel = idx;
    end
    for (int i = 0; i < 4; i++) m_ready[i] = !m_pend[i] || (m_sel == i);
  endfunction

  // State change at the clock edge.
  function automatic void m_edge();
    if (m_any_blk && m_cnt < 255) m_cnt++;
    if (m_sel >= 0) begin
      m_we = 1; m_waddr = reg_of(m_sel); m_wdata = m_buf[m_sel]; m_gid = m_sel;
      m_pend[m_sel] = 0;
      m_ptr = (m_sel + 1) % 4;
    end else begin
      m_we = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_acc[i]) begin
        m_buf[i] = d[i];
        m_pend[i] = 1;
      end
    end
  endfunction

  function automatic logic m_busy();
    return m_pend[0] | m_pend[1] | m_pend[2] | m_pend[3];
  endfunction

  // One clock cycle: compare combinational outputs mid-cycle, then the
  // registered outputs just after the rising edge.
  task automatic step();
    @(negedge clock);
    m_comb();
    check("src_ready", src_ready, m_ready);
    check("io_busy", io_busy, m_busy());
    m_acc = v & m_ready;
    @(posedge clock);
    #1;
    m_edge();
    check("io_we", io_we, m_we);
    if (m_we) begin
      check("io_waddr", io_waddr, m_waddr);
      check("io_wdata", io_wdata, m_wdata);
      check("io_grant_id", io_grant_id, m_gid);
    end
    check("conflict_count", conflict_count, m_cnt);
  endtask

  task automatic do_reset();
    @(negedge clock);
    ctrl_reset_n = 1'b0;
    #1;
    m_reset();
    check("rst_io_we", io_we, 0);
    check("rst_io_busy", io_busy, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_conflict_count", conflict_count, 0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    ctrl_reset_n = 1'b0;
    v = '0; cwe = 1'b0; cwa = '0;
    for (int i = 0; i < 4; i++) d[i] = '0;
    m_acc = '0;
    m_reset();
    #12;
    check("por_io_we", io_we, 0);
    check("por_io_waddr", io_waddr, 0);
    check("por_io_wdata", io_wdata, 0);
    check("por_io_grant_id", io_grant_id, 0);
    check("por_src_ready", src_ready, 0);
    check("por_conflict_count", conflict_count, 0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single event from the button source.
    v = 4'b0001; d[0] = 32'h0000_0001;
    step();
    v = '0;
    check("single_no_early_we", io_we, 0);
    step();
    check("single_we", io_we, 1);
    check("single_waddr", io_waddr, 20);
    check("single_wdata", io_wdata, 32'h1);
    check("single_gid", io_grant_id, 0);
    step();
    check("single_we_drop", io_we, 0);
    check("single_idle", io_busy, 0);

    // Round-robin over all four sources from a fresh pointer.
    do_reset();
    v = 4'b1111;
    for (int i = 0; i < 4; i++) d[i] = 32'hA0 + i;
    step();
    v = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("rr_we", io_we, 1);
      check("rr_waddr", io_waddr, 20 + 2 * k);
      check("rr_wdata", io_wdata, 32'hA0 + k);
    end
    v = 4'b1000; d[3] = 32'hB3;
    step();
    v = '0;
    step();
    check("rr_repost_waddr", io_waddr, 26);
    check("rr_repost_gid", io_grant_id, 3);

    // CPU conflict holds off the collision source for three cycles.
    do_reset();
    v = 4'b0100; d[2] = 32'hC0FFEE;
    step();
    v = '0; cwe = 1'b1; cwa = 5'd24;
    for (int k = 0; k < 3; k++) begin
      step();
      check("conf_blocked_we", io_we, 0);
    end
    cwe = 1'b0;
    check("conf_count", conflict_count, 3);
    step();
    check("conf_release_we", io_we, 1);
    check("conf_release_waddr", io_waddr, 24);
    check("conf_release_wdata", io_wdata, 32'hC0FFEE);

    // Back-to-back values from the screen source.
    v = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      d[1] = 32'h10 + k;
      step();
      if (k > 0) check("b2b_wdata", io_wdata, 32'h10 + k - 1);
    end
    v = '0;
    step();
    check("b2b_last_wdata", io_wdata, 32'h12);
    check("b2b_last_waddr", io_waddr, 22);

    // Backpressure on a CPU-blocked button slot.
    v = 4'b0001; d[0] = 32'h33;
    step();
    d[0] = 32'h55; cwe = 1'b1; cwa = 5'd20;
    step();
    step();
    check("bp_not_ready", src_ready[0], 0);
    cwe = 1'b0;
    step();
    check("bp_first_wdata", io_wdata, 32'h33);
    v = '0;
    step();
    check("bp_second_wdata", io_wdata, 32'h55);

    // Randomized traffic; a source not yet accepted keeps its value.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!(v[i] && !m_acc[i])) begin
          v[i] = 1'($urandom_range(0, 1));
          d[i] = $urandom;
        end
      end
      cwe = ($urandom_range(0, 2) == 0);
      begin
        int r;
        r = $urandom_range(0, 4);
        cwa = (r < 4) ? 5'(20 + 2 * r) : 5'($urandom_range(0, 31));
      end
      step();
    end
    v = '0; cwe = 1'b0;
    for (int n = 0; n < 6; n++) step();

    // Reset mid-operation with events buffered and a write in flight.
    v = 4'b0111;
    for (int i = 0; i < 3; i++) d[i] = 32'hD0 + i;
    step();
    v = '0;
    step();
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    m_reset();
    m_acc = '0;
    check("mid_rst_io_we", io_we, 0);
    check("mid_rst_io_busy", io_busy, 0);
    check("mid_rst_conflict_count", conflict_count, 0);
    check("mid_rst_src_ready", src_ready, 0);
    @(negedge clock);
    ctrl_reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("post_rst_no_we", io_we, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
